hazard_ctrl: RTL and testbench

- Pipeline hazard and forwarding controller for the 5-stage RV32I core (F/D/X/M/W).
- Keeps a shadow pipeline of register-use tags for the X, M and W stages.
- From those tags it drives the execute-stage bypass selects (rs1_bypass/rs2_bypass) and a W->D regfile bypass.
- Detects load-use hazards and stalls F/D for one cycle; on a taken branch or jump in X it flushes D and bubbles X.

---
 rtl/hazard_ctrl_pkg.sv | 51 +++++
 rtl/hazard_ctrl_tag_decode.sv | 53 +++++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared opcodes, bypass encodings and register-use tag type for the hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 7;

  localparam logic [OP_W-1:0] OP_RCC   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_MCC   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LCC   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SCC   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BCC   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BYP_NONE = 2'b00,
    BYP_MX   = 2'b01,
    BYP_WX   = 2'b10
  } bypass_e;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd;
    logic             is_load;
  } hz_tag_t;

  localparam hz_tag_t TAG_NULL = '0;

  // Execute-stage source select; a load in M is never a bypass source (load-use stall covers it).
  function automatic bypass_e bypass_sel(input logic uses, input logic [REG_W-1:0] rs,
                                         input hz_tag_t m_tag, input hz_tag_t w_tag);
    bypass_e sel;
    sel = BYP_NONE;
    if (uses && m_tag.writes_rd && !m_tag.is_load && (m_tag.rd == rs)) begin
      sel = BYP_MX;
    end else if (uses && w_tag.writes_rd && (w_tag.rd == rs)) begin
      sel = BYP_WX;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_tag_decode.sv
// Combinational instruction -> register-use tag decoder.
module hz_tag_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] i_inst,
  output hz_tag_t         o_tag
);

  logic [OP_W-1:0] w_op;
  logic            w_unused_bits;

  assign w_op          = i_inst[6:0];
  assign w_unused_bits = ^{i_inst[31:25], i_inst[14:12]};

  always_comb begin
    o_tag = TAG_NULL;
    unique case (w_op)
      OP_RCC: begin
        o_tag.uses_rs1  = 1'b1;
        o_tag.uses_rs2  = 1'b1;
        o_tag.writes_rd = 1'b1;
      end
      OP_MCC, OP_JALR: begin
        o_tag.uses_rs1  = 1'b1;
        o_tag.writes_rd = 1'b1;
      end
      OP_LCC: begin
        o_tag.uses_rs1  = 1'b1;
        o_tag.writes_rd = 1'b1;
        o_tag.is_load   = 1'b1;
      end
      OP_SCC, OP_BCC: begin
        o_tag.uses_rs1  = 1'b1;
        o_tag.uses_rs2  = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        o_tag.writes_rd = 1'b1;
      end
      default: o_tag = TAG_NULL;
    endcase

    // Register fields are only meaningful for recognised opcodes; x0 is never a destination.
    if (o_tag.uses_rs1 || o_tag.uses_rs2 || o_tag.writes_rd) begin
      o_tag.rs1 = i_inst[19:15];
      o_tag.rs2 = i_inst[24:20];
      o_tag.rd  = i_inst[11:7];
      if (i_inst[11:7] == '0) begin
        o_tag.writes_rd = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: shadow X/M/W tag pipeline, bypass selects,
// load-use stall, branch flush and saturating performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  inst_d,
  input  logic             pc_sel_x,
  output logic             stall_f,
  output logic             stall_d,
  output logic             bubble_x,
  output logic             flush_d,
  output logic [1:0]       rs1_bypass,
  output logic [1:0]       rs2_bypass,
  output logic             rs1_wd,
  output logic             rs2_wd,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hz_tag_t          w_tag_d;
  hz_tag_t          r_tag_x;
  hz_tag_t          r_tag_m;
  hz_tag_t          r_tag_w;
  logic             w_load_use;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  hz_tag_decode u_dec_d (
    .i_inst (inst_d),
    .o_tag  (w_tag_d)
  );

  // Shadow tag pipeline; a bubbled X slot carries the null tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_x <= TAG_NULL;
      r_tag_m <= TAG_NULL;
      r_tag_w <= TAG_NULL;
    end else begin
      r_tag_x <= bubble_x ? TAG_NULL : w_tag_d;
      r_tag_m <= r_tag_x;
      r_tag_w <= r_tag_m;
    end
  end

  // Hazard detection and control; a redirect overrides a pending load-use stall.
  always_comb begin
    w_load_use = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    bubble_x   = 1'b0;
    flush_d    = 1'b0;

    w_load_use = r_tag_x.is_load && r_tag_x.writes_rd &&
                 ((w_tag_d.uses_rs1 && (w_tag_d.rs1 == r_tag_x.rd)) ||
                  (w_tag_d.uses_rs2 && (w_tag_d.rs2 == r_tag_x.rd)));

    if (pc_sel_x) begin
      flush_d  = 1'b1;
      bubble_x = 1'b1;
    end else if (w_load_use) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_x = 1'b1;
    end
  end

  // Execute bypass selects and W->D regfile bypass.
  always_comb begin
    rs1_bypass = 2'(bypass_sel(r_tag_x.uses_rs1, r_tag_x.rs1, r_tag_m, r_tag_w));
    rs2_bypass = 2'(bypass_sel(r_tag_x.uses_rs2, r_tag_x.rs2, r_tag_m, r_tag_w));
    rs1_wd     = w_tag_d.uses_rs1 && r_tag_w.writes_rd && (r_tag_w.rd == w_tag_d.rs1);
    rs2_wd     = w_tag_d.uses_rs2 && r_tag_w.writes_rd && (r_tag_w.rd == w_tag_d.rs2);
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_d && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush_d && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (counters narrowed to 4 bits to reach saturation).
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned CW = 4;

  localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] I_ADD_X2_11  = 32'h0010_8133;
  localparam logic [31:0] I_ADD_X2_10  = 32'h0000_8133;
  localparam logic [31:0] I_ADD_X6_10  = 32'h0000_8333;
  localparam logic [31:0] I_LW_X3      = 32'h0000_2183;
  localparam logic [31:0] I_ADD_X4_30  = 32'h0001_8233;
  localparam logic [31:0] I_SW_X3      = 32'h0030_2023;
  localparam logic [31:0] I_ADDI_X0_7  = 32'h0070_0013;
  localparam logic [31:0] I_ADD_X5_00  = 32'h0000_02B3;
  localparam logic [31:0] I_BEQ        = 32'h0000_0063;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   inst_d;
  logic          pc_sel_x;
  logic          stall_f, stall_d, bubble_x, flush_d;
  logic [1:0]    rs1_bypass, rs2_bypass;
  logic          rs1_wd, rs2_wd;
  logic [CW-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_d      (inst_d),
    .pc_sel_x    (pc_sel_x),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .bubble_x    (bubble_x),
    .flush_d     (flush_d),
    .rs1_bypass  (rs1_bypass),
    .rs2_bypass  (rs2_bypass),
    .rs1_wd      (rs1_wd),
    .rs2_wd      (rs2_wd),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    inst_d   = NOP_INST;
    pc_sel_x = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({stall_f, stall_d, bubble_x, flush_d} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {stall_f, stall_d, bubble_x, flush_d});
    end
    checks++;
    if ({rs1_bypass, rs2_bypass, rs1_wd, rs2_wd} !== 6'b0) begin
      errors++; $display("FAIL reset_byp got %b exp 000000", {rs1_bypass, rs2_bypass, rs1_wd, rs2_wd});
    end
    checks++;
    if ({stall_count, flush_count} !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_count, flush_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    inst_d = I_ADDI_X1_5;
    tick();
    inst_d = I_ADD_X2_11;
    #1;
    checks++;
    if (stall_d !== 1'b0 || bubble_x !== 1'b0) begin
      errors++; $display("FAIL b2b_nostall got stall=%b bubble=%b exp 0 0", stall_d, bubble_x);
    end
    tick();
    inst_d = NOP_INST;
    #1;
    checks++;
    if (rs1_bypass !== BYP_MX || rs2_bypass !== BYP_MX) begin
      errors++; $display("FAIL b2b_mx got %b/%b exp 01/01", rs1_bypass, rs2_bypass);
    end
  endtask

  task automatic test_wx_and_wd();
    do_reset();
    inst_d = I_ADDI_X1_5;
    tick();
    inst_d = NOP_INST;
    tick();
    inst_d = I_ADD_X2_10;
    #1;
    checks++;
    if (rs1_wd !== 1'b0) begin
      errors++; $display("FAIL wx_early_wd got %b exp 0", rs1_wd);
    end
    tick();
    inst_d = I_ADD_X6_10;
    #1;
    checks++;
    if (rs1_bypass !== BYP_WX || rs2_bypass !== BYP_NONE) begin
      errors++; $display("FAIL wx_sel got %b/%b exp 10/00", rs1_bypass, rs2_bypass);
    end
    checks++;
    if (rs1_wd !== 1'b1 || rs2_wd !== 1'b0) begin
      errors++; $display("FAIL wd_bypass got %b/%b exp 1/0", rs1_wd, rs2_wd);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    inst_d = I_LW_X3;
    tick();
    inst_d = I_ADD_X4_30;
    #1;
    checks++;
    if ({stall_f, stall_d, bubble_x, flush_d} !== 4'b1110) begin
      errors++; $display("FAIL lu_stall got %b exp 1110", {stall_f, stall_d, bubble_x, flush_d});
    end
    tick();
    #1;
    checks++;
    if ({stall_f, stall_d, bubble_x} !== 3'b000) begin
      errors++; $display("FAIL lu_release got %b exp 000", {stall_f, stall_d, bubble_x});
    end
    tick();
    inst_d = NOP_INST;
    #1;
    checks++;
    if (rs1_bypass !== BYP_WX || rs2_bypass !== BYP_NONE) begin
      errors++; $display("FAIL lu_wx got %b/%b exp 10/00", rs1_bypass, rs2_bypass);
    end
    checks++;
    if (stall_count !== 4'd1) begin
      errors++; $display("FAIL lu_count got %0d exp 1", stall_count);
    end
    // Store data operand matching the load destination also stalls.
    inst_d = I_LW_X3;
    tick();
    inst_d = I_SW_X3;
    #1;
    checks++;
    if (stall_d !== 1'b1) begin
      errors++; $display("FAIL lu_store got %b exp 1", stall_d);
    end
  endtask

  task automatic test_x0();
    do_reset();
    inst_d = I_ADDI_X0_7;
    tick();
    inst_d = I_ADD_X5_00;
    #1;
    checks++;
    if (stall_d !== 1'b0 || rs1_wd !== 1'b0 || rs2_wd !== 1'b0) begin
      errors++; $display("FAIL x0_d got stall=%b wd=%b%b exp 0 00", stall_d, rs1_wd, rs2_wd);
    end
    tick();
    inst_d = NOP_INST;
    #1;
    checks++;
    if (rs1_bypass !== BYP_NONE || rs2_bypass !== BYP_NONE) begin
      errors++; $display("FAIL x0_sel got %b/%b exp 00/00", rs1_bypass, rs2_bypass);
    end
  endtask

  task automatic test_flush();
    do_reset();
    inst_d = I_LW_X3;
    tick();
    inst_d   = I_ADD_X4_30;
    pc_sel_x = 1'b1;
    #1;
    checks++;
    if ({stall_f, stall_d, bubble_x, flush_d} !== 4'b0011) begin
      errors++; $display("FAIL flush_over_stall got %b exp 0011", {stall_f, stall_d, bubble_x, flush_d});
    end
    tick();
    pc_sel_x = 1'b0;
    inst_d   = I_BEQ;
    #1;
    checks++;
    if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
      errors++; $display("FAIL flush_cnt1 got f=%0d s=%0d exp 1 0", flush_count, stall_count);
    end
    tick();
    inst_d   = I_ADD_X4_30;
    pc_sel_x = 1'b1;
    #1;
    checks++;
    if ({stall_f, stall_d, bubble_x, flush_d} !== 4'b0011) begin
      errors++; $display("FAIL flush_beq got %b exp 0011", {stall_f, stall_d, bubble_x, flush_d});
    end
    tick();
    pc_sel_x = 1'b0;
    inst_d   = NOP_INST;
    #1;
    checks++;
    if (flush_count !== 4'd2 || stall_count !== 4'd0) begin
      errors++; $display("FAIL flush_cnt2 got f=%0d s=%0d exp 2 0", flush_count, stall_count);
    end
  endtask

  task automatic test_reset_in_stall();
    do_reset();
    inst_d = I_LW_X3;
    tick();
    inst_d = I_ADD_X4_30;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({stall_f, stall_d, bubble_x, flush_d, rs1_bypass, rs2_bypass} !== 8'b0) begin
      errors++; $display("FAIL rst_stall_ctrl got %b exp 00000000",
                         {stall_f, stall_d, bubble_x, flush_d, rs1_bypass, rs2_bypass});
    end
    checks++;
    if ({stall_count, flush_count} !== '0) begin
      errors++; $display("FAIL rst_stall_cnt got %0d/%0d exp 0/0", stall_count, flush_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      inst_d = I_LW_X3;
      tick();
      inst_d = I_ADD_X4_30;
      tick();
    end
    #1;
    checks++;
    if (stall_count !== 4'd15) begin
      errors++; $display("FAIL sat_stall got %0d exp 15", stall_count);
    end
    inst_d   = NOP_INST;
    pc_sel_x = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    pc_sel_x = 1'b0;
    #1;
    checks++;
    if (flush_count !== 4'd15 || stall_count !== 4'd15) begin
      errors++; $display("FAIL sat_flush got f=%0d s=%0d exp 15 15", flush_count, stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wx_and_wd();
    test_load_use();
    test_x0();
    test_flush();
    test_reset_in_stall();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
